// File: rtl/fmap_pkg.sv
// Shared definitions for the padded feature-map buffer: default geometry,
// padded-size and counter-width helpers, and the writer FSM encoding.
package fmap_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_OUT_CHANNELS = 3;
    localparam int DEF_IN_WIDTH     = 5;
    localparam int DEF_IN_HEIGHT    = 5;

    function automatic int pad_dim(input int n);
        return n + 2;
    endfunction

    function automatic int fmap_depth(input int in_w, input int in_h, input int ch);
        return (in_w + 2) * (in_h + 2) * ch;
    endfunction

    // Width able to index 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } wr_state_e;

endpackage

// File: rtl/padded_pos_counter.sv
// Row/column/channel walker over the padded frame with a linear address kept
// alongside, so the buffer address never needs a multiplier.
module padded_pos_counter
    import fmap_pkg::*;
#(
    parameter int PAD_WIDTH    = pad_dim(DEF_IN_WIDTH),
    parameter int PAD_HEIGHT   = pad_dim(DEF_IN_HEIGHT),
    parameter int OUT_CHANNELS = DEF_OUT_CHANNELS,
    parameter int AW           = cnt_width(PAD_WIDTH * PAD_HEIGHT * OUT_CHANNELS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          load_interior_i,
    input  logic          skip_border_i,
    input  logic          step_i,
    output logic [AW-1:0] addr_o,
    output logic          border_o,
    output logic          last_o
);

    localparam int RW  = cnt_width(PAD_HEIGHT);
    localparam int CW  = cnt_width(PAD_WIDTH);
    localparam int CHW = cnt_width(OUT_CHANNELS);

    localparam logic [RW-1:0]  ROW_LAST     = RW'(PAD_HEIGHT - 1);
    localparam logic [RW-1:0]  ROW_INT_LAST = RW'(PAD_HEIGHT - 2);
    localparam logic [CW-1:0]  COL_LAST     = CW'(PAD_WIDTH - 1);
    localparam logic [CW-1:0]  COL_INT_LAST = CW'(PAD_WIDTH - 2);
    localparam logic [CHW-1:0] CH_LAST      = CHW'(OUT_CHANNELS - 1);
    localparam logic [AW-1:0]  INT_START    = AW'((PAD_WIDTH + 1) * OUT_CHANNELS);
    localparam logic [AW-1:0]  ROW_SKIP     = AW'(2 * OUT_CHANNELS + 1);

    logic [RW-1:0]  row_q, row_d;
    logic [CW-1:0]  col_q, col_d;
    logic [CHW-1:0] ch_q,  ch_d;
    logic [AW-1:0]  addr_q, addr_d;

    logic ch_last;
    logic col_int_last;

    assign ch_last      = (ch_q == CH_LAST);
    assign col_int_last = (col_q == COL_INT_LAST);

    assign border_o = (row_q == '0) | (row_q == ROW_LAST) | (col_q == '0) | (col_q == COL_LAST);
    assign last_o   = skip_border_i ? ((row_q == ROW_INT_LAST) & col_int_last & ch_last)
                                    : ((row_q == ROW_LAST) & (col_q == COL_LAST) & ch_last);
    assign addr_o   = addr_q;

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        ch_d   = ch_q;
        addr_d = addr_q;
        if (load_i) begin
            row_d  = load_interior_i ? RW'(1) : '0;
            col_d  = load_interior_i ? CW'(1) : '0;
            ch_d   = '0;
            addr_d = load_interior_i ? INT_START : '0;
        end else if (step_i) begin
            if (last_o) begin
                row_d  = '0;
                col_d  = '0;
                ch_d   = '0;
                addr_d = '0;
            end else if (ch_last) begin
                ch_d = '0;
                // Interior-only walks hop over the right and left border columns.
                if (skip_border_i && col_int_last) begin
                    row_d  = row_q + RW'(1);
                    col_d  = CW'(1);
                    addr_d = addr_q + ROW_SKIP;
                end else if (col_q == COL_LAST) begin
                    row_d  = row_q + RW'(1);
                    col_d  = '0;
                    addr_d = addr_q + AW'(1);
                end else begin
                    col_d  = col_q + CW'(1);
                    addr_d = addr_q + AW'(1);
                end
            end else begin
                ch_d   = ch_q + CHW'(1);
                addr_d = addr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            col_q  <= '0;
            ch_q   <= '0;
            addr_q <= '0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            ch_q   <= ch_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/padded_fmap_writer.sv
// Write-side sequencer filling the padded feature-map buffer from a pixel stream.
// Optional macro PADDED_FMAP_WR_PAD_ONCE_EN: after the first frame, skip border writes.
module padded_fmap_writer
    import fmap_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int OUT_CHANNELS = DEF_OUT_CHANNELS,
    parameter int IN_WIDTH     = DEF_IN_WIDTH,
    parameter int IN_HEIGHT    = DEF_IN_HEIGHT,
    localparam int PAD_WIDTH   = pad_dim(IN_WIDTH),
    localparam int PAD_HEIGHT  = pad_dim(IN_HEIGHT),
    localparam int DEPTH       = fmap_depth(IN_WIDTH, IN_HEIGHT, OUT_CHANNELS),
    localparam int AW          = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [AW-1:0]         wr_addr,
    output logic                  is_padding,
    output logic                  wr_en,
    output logic                  busy,
    output logic                  done,
    output logic                  state_dbg_o
);

    wr_state_e state_q, state_d;

    logic                  step;
    logic                  start_ok;
    logic                  skip_border;
    logic [AW-1:0]         pos_addr;
    logic                  pos_border;
    logic                  pos_last;

    logic                  wr_en_q;
    logic [AW-1:0]         wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  is_pad_q;
    logic                  done_q;

`ifdef PADDED_FMAP_WR_PAD_ONCE_EN
    logic pad_written_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_written_q <= 1'b0;
        end else if (done_q) begin
            pad_written_q <= 1'b1;
        end
    end

    assign skip_border = pad_written_q;
`else
    assign skip_border = 1'b0;
`endif

    padded_pos_counter #(
        .PAD_WIDTH   (PAD_WIDTH),
        .PAD_HEIGHT  (PAD_HEIGHT),
        .OUT_CHANNELS(OUT_CHANNELS),
        .AW          (AW)
    ) u_pos (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_i         (start_ok),
        .load_interior_i(skip_border),
        .skip_border_i  (skip_border),
        .step_i         (step),
        .addr_o         (pos_addr),
        .border_o       (pos_border),
        .last_o         (pos_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = WALK;
            WALK:    if (step && pos_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake: an element transfers on a rising edge where in_valid & in_ready.
    // in_ready depends only on state and position, never on in_valid; border
    // positions step every cycle without consuming stream data.
    always_comb begin
        start_ok = 1'b0;
        step     = 1'b0;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                start_ok = start & ~done_q;
            end
            WALK: begin
                busy     = 1'b1;
                in_ready = ~pos_border;
                step     = pos_border | in_valid;
            end
            default: begin
                start_ok = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            is_pad_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wr_en_q <= step;
            done_q  <= step & pos_last;
            if (step) begin
                wr_addr_q <= pos_addr;
                wr_data_q <= pos_border ? '0 : in_data;
                is_pad_q  <= pos_border;
            end
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign is_padding  = is_pad_q;
    assign done        = done_q;
    assign state_dbg_o = state_q;

endmodule
